// File: rtl/saturating_requantizer.sv
// Two-stage multi-lane requantizer: S1 rounds and arithmetically shifts each lane,
// S2 saturates to the output format; valid/ready with full backpressure and debug counters.
module saturating_requantizer #(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int FRAC_SHIFT   = 8,
    parameter int ROUND_EN     = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              in_valid_in,
    output logic                              in_ready_out,
    input  logic [NUM_CHANNELS*IN_WIDTH-1:0]  data_in,
    output logic                              out_valid_out,
    input  logic                              out_ready_in,
    output logic [NUM_CHANNELS*OUT_WIDTH-1:0] data_out,
    output logic [NUM_CHANNELS-1:0]           sat_hi_out,
    output logic [NUM_CHANNELS-1:0]           sat_lo_out,
    input  logic                              clear_counts_in,
    output logic [COUNT_WIDTH-1:0]            overflow_count_out,
    output logic [COUNT_WIDTH-1:0]            underflow_count_out
);

    // One guard bit so max positive input plus the rounding constant cannot wrap.
    localparam int S1_W   = IN_WIDTH + 1;
    localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam int PC_W   = $clog2(NUM_CHANNELS + 1);

    localparam logic signed [S1_W-1:0] RND_C =
        (ROUND_EN != 0 && FRAC_SHIFT > 0) ? (S1_W'(1) << RND_SH) : '0;
    localparam logic signed [S1_W-1:0] OUT_MAX =
        {{(S1_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [S1_W-1:0] OUT_MIN =
        {{(S1_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                        hi;
        logic                        lo;
        logic signed [OUT_WIDTH-1:0] val;
    } sat_t;

    function automatic logic signed [S1_W-1:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
        logic signed [S1_W-1:0] ext;
        ext = {x[IN_WIDTH-1], x};
        ext = ext + RND_C;
        return ext >>> FRAC_SHIFT;
    endfunction

    function automatic sat_t saturate(input logic signed [S1_W-1:0] v);
        sat_t r;
        r.hi  = 1'b0;
        r.lo  = 1'b0;
        r.val = v[OUT_WIDTH-1:0];
        if (v > OUT_MAX) begin
            r.hi  = 1'b1;
            r.val = OUT_MAX[OUT_WIDTH-1:0];
        end else if (v < OUT_MIN) begin
            r.lo  = 1'b1;
            r.val = OUT_MIN[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_CHANNELS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] c,
                                                       input logic [PC_W-1:0] n);
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, c} + (COUNT_WIDTH+1)'(n);
        return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
    endfunction

    logic                   vld_p1;
    logic signed [S1_W-1:0] lane_p1 [NUM_CHANNELS];
    sat_t                   sat_p1  [NUM_CHANNELS];
    logic                   s1_en, s2_en, out_xfer;

    assign s2_en        = !out_valid_out || out_ready_in;
    assign s1_en        = !vld_p1 || s2_en;
    assign in_ready_out = s1_en;
    assign out_xfer     = out_valid_out && out_ready_in;

    // Stage 1: round and shift
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)     vld_p1 <= 1'b0;
        else if (s1_en) vld_p1 <= in_valid_in;
    end

    always_ff @(posedge clk_in) begin
        if (s1_en && in_valid_in) begin
            for (int k = 0; k < NUM_CHANNELS; k++)
                lane_p1[k] <= round_shift(data_in[k*IN_WIDTH +: IN_WIDTH]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) sat_p1[k] = saturate(lane_p1[k]);
    end

    // Stage 2: saturate and register outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid_out <= 1'b0;
            data_out      <= '0;
            sat_hi_out    <= '0;
            sat_lo_out    <= '0;
        end else if (s2_en) begin
            out_valid_out <= vld_p1;
            if (vld_p1) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    data_out[k*OUT_WIDTH +: OUT_WIDTH] <= sat_p1[k].val;
                    sat_hi_out[k]                      <= sat_p1[k].hi;
                    sat_lo_out[k]                      <= sat_p1[k].lo;
                end
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overflow_count_out  <= '0;
            underflow_count_out <= '0;
        end else if (clear_counts_in) begin
            overflow_count_out  <= '0;
            underflow_count_out <= '0;
        end else if (out_xfer) begin
            overflow_count_out  <= sat_add(overflow_count_out, popcount(sat_hi_out));
            underflow_count_out <= sat_add(underflow_count_out, popcount(sat_lo_out));
        end
    end

endmodule

// File: tb/tb_saturating_requantizer.sv
// Bench for saturating_requantizer: three parameterisations share one stimulus stream
// and are compared each cycle against a queue-level arithmetic model plus literal vectors.
module tb_saturating_requantizer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic clear = 1'b0;
    logic [127:0] data_in = '0;

    logic r0, r1, r2, v0, v1, v2;
    logic [63:0] d0, d1, d2;
    logic [3:0] h0, h1, h2, l0, l1, l2;
    logic [15:0] o0, u0, o1, u1;
    logic [3:0] o2, u2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    saturating_requantizer dut_rnd (
        .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid), .in_ready_out(r0),
        .data_in(data_in), .out_valid_out(v0), .out_ready_in(out_ready), .data_out(d0),
        .sat_hi_out(h0), .sat_lo_out(l0), .clear_counts_in(clear),
        .overflow_count_out(o0), .underflow_count_out(u0));

    saturating_requantizer #(.ROUND_EN(0)) dut_trn (
        .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid), .in_ready_out(r1),
        .data_in(data_in), .out_valid_out(v1), .out_ready_in(out_ready), .data_out(d1),
        .sat_hi_out(h1), .sat_lo_out(l1), .clear_counts_in(clear),
        .overflow_count_out(o1), .underflow_count_out(u1));

    saturating_requantizer #(.COUNT_WIDTH(4)) dut_c4 (
        .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid), .in_ready_out(r2),
        .data_in(data_in), .out_valid_out(v2), .out_ready_in(out_ready), .data_out(d2),
        .sat_hi_out(h2), .sat_lo_out(l2), .clear_counts_in(clear),
        .overflow_count_out(o2), .underflow_count_out(u2));

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Scale by 1/256 with optional half-up rounding, then clamp to int16.
    task automatic exp_lane(input logic [127:0] b, input int k, input bit rnd,
                            output longint val, output bit hi, output bit lo);
        logic signed [31:0] x;
        longint qv;
        x  = b[k*32 +: 32];
        qv = floor_div(longint'(x) + (rnd ? 128 : 0), 256);
        hi = 1'b0;
        lo = 1'b0;
        val = qv;
        if (qv > 32767) begin
            val = 32767;
            hi  = 1'b1;
        end else if (qv < -32768) begin
            val = -32768;
            lo  = 1'b1;
        end
    endtask

    function automatic longint lane16(input logic [63:0] d, input int k);
        logic signed [15:0] t;
        t = d[k*16 +: 16];
        return longint'(t);
    endfunction

    // Model: beats in flight, whether the oldest is presented, per-DUT counters.
    logic [127:0] q[$];
    bit vis = 1'b0;
    longint cov[3] = '{0, 0, 0};
    longint cun[3] = '{0, 0, 0};
    longint cmax[3] = '{65535, 65535, 15};
    bit rnd_of[3] = '{1'b1, 1'b0, 1'b1};

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            vis = 1'b0;
            for (int k = 0; k < 3; k++) begin cov[k] = 0; cun[k] = 0; end
        end else begin
            bit xo, xi;
            xo = vis && out_ready;
            xi = in_valid && ((q.size() < 2) || out_ready);
            if (xo) begin
                for (int k = 0; k < 3; k++) begin
                    longint nh, nl, ev;
                    bit eh, el;
                    nh = 0; nl = 0;
                    for (int j = 0; j < 4; j++) begin
                        exp_lane(q[0], j, rnd_of[k], ev, eh, el);
                        nh += eh; nl += el;
                    end
                    cov[k] = (cov[k] + nh > cmax[k]) ? cmax[k] : cov[k] + nh;
                    cun[k] = (cun[k] + nl > cmax[k]) ? cmax[k] : cun[k] + nl;
                end
                void'(q.pop_front());
                vis = 1'b0;
            end
            if (clear) for (int k = 0; k < 3; k++) begin cov[k] = 0; cun[k] = 0; end
            if (!vis && q.size() > 0) vis = 1'b1;
            if (xi) q.push_back(data_in);
        end
    end

    task automatic check_dut(input int k, input logic rdy, input logic vld, input logic [63:0] d,
                             input logic [3:0] h, input logic [3:0] l,
                             input longint ov, input longint un);
        longint ev;
        bit eh, el;
        check($sformatf("dut%0d_in_ready", k), rdy, ((q.size() < 2) || out_ready) ? 1 : 0);
        check($sformatf("dut%0d_out_valid", k), vld, vis ? 1 : 0);
        if (vis && q.size() > 0) begin
            for (int j = 0; j < 4; j++) begin
                exp_lane(q[0], j, rnd_of[k], ev, eh, el);
                check($sformatf("dut%0d_lane%0d", k, j), lane16(d, j), ev);
                check($sformatf("dut%0d_hi%0d", k, j), h[j], eh);
                check($sformatf("dut%0d_lo%0d", k, j), l[j], el);
            end
        end
        check($sformatf("dut%0d_ovf_cnt", k), ov, cov[k]);
        check($sformatf("dut%0d_unf_cnt", k), un, cun[k]);
    endtask

    initial forever begin
        @(negedge clk);
        check_dut(0, r0, v0, d0, h0, l0, o0, u0);
        check_dut(1, r1, v1, d1, h1, l1, o1, u1);
        check_dut(2, r2, v2, d2, h2, l2, o2, u2);
    end

    task automatic send_beat(input logic [127:0] b);
        bit rdy;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        data_in  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = r0;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = v0;
        end
        if (!seen) check("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q.size() > 0 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    localparam logic [127:0] RND_BEAT = {32'd0, 32'd4735, 32'hFFFFFE80, 32'd4736};
    localparam logic [127:0] SAT_BEAT = {32'd8388608, 32'd8388352, 32'h80000000, 32'h7FFFFFFF};
    localparam logic [127:0] OVF_BEAT = {4{32'h7FFFFFFF}};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", v0, 0);
        check("rst_data", d0, 0);
        check("rst_sat_hi", h0, 0);
        check("rst_sat_lo", l0, 0);
        check("rst_ovf_cnt", o0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Rounding and 2-cycle latency
        send_beat(RND_BEAT);
        @(negedge clk);
        check("round_lat_c1", v0, 0);
        @(negedge clk);
        check("round_lat_c2", v0, 1);
        check("round_l0", lane16(d0, 0), 19);
        check("round_l1", lane16(d0, 1), -1);
        check("round_l2", lane16(d0, 2), 18);
        check("round_l3", lane16(d0, 3), 0);
        check("round_flags", {h0, l0}, 0);
        check("trunc_l0", lane16(d1, 0), 18);
        check("trunc_l1", lane16(d1, 1), -2);
        check("trunc_l2", lane16(d1, 2), 18);
        drain();

        // Saturation
        pulse_clear();
        send_beat(SAT_BEAT);
        wait_out();
        check("sat_l0", lane16(d0, 0), 32767);
        check("sat_l1", lane16(d0, 1), -32768);
        check("sat_l2", lane16(d0, 2), 32767);
        check("sat_l3", lane16(d0, 3), 32767);
        check("sat_hi", h0, 4'b1001);
        check("sat_lo", l0, 4'b0010);
        check("trunc_sat_hi", h1, 4'b1001);
        check("trunc_sat_lo", l1, 4'b0010);
        @(posedge clk);
        #1;
        check("sat_ovf_cnt", o0, 2);
        check("sat_unf_cnt", u0, 1);
        check("trunc_ovf_cnt", o1, 2);

        // Backpressure: six back-to-back beats, downstream stalled for cycles 3..7
        pulse_clear();
        fork
            for (int i = 0; i < 6; i++)
                send_beat({32'sd100 * i, -32'sd256 * (i + 1), 32'sd256 * (i + 1), 32'h40000000});
            for (int c = 0; c < 12; c++) begin
                out_ready = !(c >= 3 && c <= 7);
                @(posedge clk);
                #1;
            end
        join
        out_ready = 1'b1;
        drain();
        check("bp_ovf_cnt", o0, 6);
        check("bp_unf_cnt", u0, 0);

        // Counter saturation at COUNT_WIDTH=4
        pulse_clear();
        for (int i = 0; i < 5; i++) send_beat(OVF_BEAT);
        drain();
        check("c4_ovf_stuck", o2, 15);
        check("c16_ovf_cnt", o0, 20);

        // Clear coinciding with a saturating transfer
        send_beat(OVF_BEAT);
        wait_out();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_win_c16", o0, 0);
        check("clr_win_c4", o2, 0);

        // Reset with both stages full
        send_beat(SAT_BEAT);
        drain();
        out_ready = 1'b0;
        send_beat(OVF_BEAT);
        send_beat(RND_BEAT);
        @(negedge clk);
        check("full_in_ready", r0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", v0, 0);
        check("midrst_ovf_cnt", o0, 0);
        check("midrst_unf_cnt", u0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_beat(RND_BEAT);
        @(negedge clk);
        check("post_rst_lat_c1", v0, 0);
        @(negedge clk);
        check("post_rst_lat_c2", v0, 1);
        check("post_rst_l0", lane16(d0, 0), 19);
        drain();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
